// File: rtl/fft_peak_detect_pkg.sv
// Shared constants, state encoding and {re, im} bin-word field helpers for the
// FFT back-end blocks.
package fft_peak_detect_pkg;

  localparam int DW     = 16;
  localparam int MAG_W  = 2 * DW;
  localparam int N_BINS = 16;
  localparam int BIN_W  = 2 * DW;
  localparam int IDX_W  = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic logic signed [DW-1:0] bin_re(input logic [BIN_W-1:0] w);
    return w[BIN_W-1:DW];
  endfunction

  function automatic logic signed [DW-1:0] bin_im(input logic [BIN_W-1:0] w);
    return w[DW-1:0];
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one {re, im} bin word.
module fft_mag_sq
  import fft_peak_detect_pkg::*;
(
  input  logic [BIN_W-1:0] bin,
  output logic [MAG_W-1:0] mag
);

  logic signed [DW-1:0]   re;
  logic signed [DW-1:0]   im;
  logic signed [2*DW-1:0] re_x;
  logic signed [2*DW-1:0] im_x;
  logic signed [2*DW-1:0] re_sq;
  logic signed [2*DW-1:0] im_sq;

  assign re = bin_re(bin);
  assign im = bin_im(bin);

  // Widen before multiplying; each square is at most 2^30, so the signed
  // product never overflows, and the sum of two fits unsigned in MAG_W.
  assign re_x  = {{DW{re[DW-1]}}, re};
  assign im_x  = {{DW{im[DW-1]}}, im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_peak_detect.sv
// Serial peak-bin finder for a 16-point FFT frame: one bin per cycle, with a
// one-frame shadow buffer so back-to-back frames stream without bubbles.
module fft_peak_detect
  import fft_peak_detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fft_valid,
  input  logic [BIN_W-1:0] fft_d0,
  input  logic [BIN_W-1:0] fft_d1,
  input  logic [BIN_W-1:0] fft_d2,
  input  logic [BIN_W-1:0] fft_d3,
  input  logic [BIN_W-1:0] fft_d4,
  input  logic [BIN_W-1:0] fft_d5,
  input  logic [BIN_W-1:0] fft_d6,
  input  logic [BIN_W-1:0] fft_d7,
  input  logic [BIN_W-1:0] fft_d8,
  input  logic [BIN_W-1:0] fft_d9,
  input  logic [BIN_W-1:0] fft_d10,
  input  logic [BIN_W-1:0] fft_d11,
  input  logic [BIN_W-1:0] fft_d12,
  input  logic [BIN_W-1:0] fft_d13,
  input  logic [BIN_W-1:0] fft_d14,
  input  logic [BIN_W-1:0] fft_d15,
  output logic             done,
  output logic [IDX_W-1:0] freq,
  output logic             busy,
  output logic             overrun
);

  logic [BIN_W-1:0] in_w       [N_BINS];
  logic [BIN_W-1:0] main_buf   [N_BINS];
  logic [BIN_W-1:0] shadow_buf [N_BINS];
  logic             shadow_valid;
  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [MAG_W-1:0] max_mag;
  logic [IDX_W-1:0] max_idx;
  logic [MAG_W-1:0] mag;
  logic             is_greater;
  logic             last;
  logic [IDX_W-1:0] winner;

  assign in_w = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  fft_mag_sq u_mag (
    .bin (main_buf[idx]),
    .mag (mag)
  );

  // Strict compare keeps the lowest index on ties.
  assign is_greater = (mag > max_mag);
  assign last       = (state == ST_BUSY) && (idx == LAST_IDX);
  assign winner     = is_greater ? idx : max_idx;
  assign busy       = (state == ST_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      max_mag      <= '0;
      max_idx      <= '0;
      shadow_valid <= 1'b0;
      done         <= 1'b0;
      freq         <= '0;
      overrun      <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fft_valid) begin
            state   <= ST_BUSY;
            idx     <= '0;
            max_mag <= '0;
            max_idx <= '0;
          end
        end
        default: begin
          if (!last) begin
            if (is_greater) begin
              max_mag <= mag;
              max_idx <= idx;
            end
            idx <= idx + 1'b1;
            if (fft_valid) begin
              shadow_valid <= 1'b1;
              overrun      <= shadow_valid;
            end
          end else begin
            done    <= 1'b1;
            freq    <= winner;
            idx     <= '0;
            max_mag <= '0;
            max_idx <= '0;
            // Pending shadow frame first; a simultaneous new frame refills it.
            if (shadow_valid) begin
              shadow_valid <= fft_valid;
            end else if (!fft_valid) begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_IDLE) begin
        if (fft_valid) main_buf <= in_w;
      end else if (!last) begin
        if (fft_valid) shadow_buf <= in_w;
      end else if (shadow_valid) begin
        main_buf <= shadow_buf;
        if (fft_valid) shadow_buf <= in_w;
      end else if (fft_valid) begin
        main_buf <= in_w;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: single frame, ties, extremes, streaming,
// overrun and mid-scan reset, checked cycle by cycle.
module tb_fft_peak_detect;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done;
  logic [3:0]  freq;
  logic        busy;
  logic        overrun;
  int          n_cmp;
  int          n_bad;

  localparam logic [31:0] NOISE = {16'h0010, 16'h0000};
  localparam logic [31:0] PEAK  = {16'h0100, 16'h0000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_peak_detect dut (
    .clk (clk), .rst (rst), .fft_valid (fft_valid),
    .fft_d0 (d[0]), .fft_d1 (d[1]), .fft_d2 (d[2]), .fft_d3 (d[3]),
    .fft_d4 (d[4]), .fft_d5 (d[5]), .fft_d6 (d[6]), .fft_d7 (d[7]),
    .fft_d8 (d[8]), .fft_d9 (d[9]), .fft_d10 (d[10]), .fft_d11 (d[11]),
    .fft_d12 (d[12]), .fft_d13 (d[13]), .fft_d14 (d[14]), .fft_d15 (d[15]),
    .done (done), .freq (freq), .busy (busy), .overrun (overrun)
  );

  // Driver tasks: called right after a negedge, inputs apply to that cycle.
  task automatic drive_idle();
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = '0;
  endtask

  task automatic drive_frame(input int peak, input logic [31:0] pw, input logic [31:0] other);
    fft_valid = 1'b1;
    for (int i = 0; i < 16; i++) d[i] = (i == peak) ? pw : other;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 4;
    if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    if (freq !== 4'd0)    begin n_bad++; $display("FAIL reset_freq got=%0d exp=0", freq); end
    if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  // Frame at cycle 0 with only bin 5 nonzero: done at 17, busy 1..16.
  task automatic test_single();
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      n_cmp += 3;
      if (done !== (cyc == 17)) begin n_bad++; $display("FAIL single_done cyc=%0d got=%b exp=%b", cyc, done, cyc == 17); end
      if (busy !== (cyc >= 1 && cyc <= 16)) begin n_bad++; $display("FAIL single_busy cyc=%0d got=%b", cyc, busy); end
      if (overrun !== 1'b0) begin n_bad++; $display("FAIL single_overrun cyc=%0d got=%b exp=0", cyc, overrun); end
      if (cyc == 17) begin
        n_cmp++;
        if (freq !== 4'd5) begin n_bad++; $display("FAIL single_freq got=%0d exp=5", freq); end
      end
      if (cyc == 0) drive_frame(5, PEAK, 32'h0); else drive_idle();
    end
  endtask

  // Bins 3 and 9 equal; lowest index must win.
  task automatic test_tie();
    @(negedge clk);
    for (int cyc = 0; cyc <= 18; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 17) begin
        n_cmp += 2;
        if (done !== 1'b1) begin n_bad++; $display("FAIL tie_done got=%b exp=1", done); end
        if (freq !== 4'd3) begin n_bad++; $display("FAIL tie_freq got=%0d exp=3", freq); end
      end
      if (cyc == 0) begin
        drive_frame(3, {16'h0040, 16'hFFC0}, 32'h0);
        d[9] = {16'h0040, 16'hFFC0};
      end else drive_idle();
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    for (int cyc = 0; cyc <= 18; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 17) begin
        n_cmp += 2;
        if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done got=%b exp=1", done); end
        if (freq !== 4'd0) begin n_bad++; $display("FAIL zero_freq got=%0d exp=0", freq); end
      end
      if (cyc == 0) drive_frame(0, 32'h0, 32'h0); else drive_idle();
    end
  endtask

  // 2^31 (bin 12) must beat 2*32767^2 (bin 2) without wrapping.
  task automatic test_extreme();
    @(negedge clk);
    for (int cyc = 0; cyc <= 18; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 17) begin
        n_cmp += 2;
        if (done !== 1'b1)  begin n_bad++; $display("FAIL extreme_done got=%b exp=1", done); end
        if (freq !== 4'd12) begin n_bad++; $display("FAIL extreme_freq got=%0d exp=12", freq); end
      end
      if (cyc == 0) begin
        drive_frame(12, {16'h8000, 16'h8000}, 32'h0);
        d[2] = {16'h7FFF, 16'h7FFF};
      end else drive_idle();
    end
  endtask

  task automatic test_back_to_back();
    int peaks [4];
    peaks = '{1, 7, 14, 0};
    @(negedge clk);
    for (int cyc = 0; cyc <= 70; cyc++) begin
      if (cyc > 0) @(negedge clk);
      n_cmp += 3;
      if (done !== (cyc == 17 || cyc == 33 || cyc == 49 || cyc == 65)) begin
        n_bad++; $display("FAIL b2b_done cyc=%0d got=%b", cyc, done);
      end
      if (busy !== (cyc >= 1 && cyc <= 64)) begin n_bad++; $display("FAIL b2b_busy cyc=%0d got=%b", cyc, busy); end
      if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun cyc=%0d got=%b exp=0", cyc, overrun); end
      if (cyc >= 17 && (cyc - 1) % 16 == 0 && cyc <= 65) begin
        n_cmp++;
        if (freq !== 4'(peaks[(cyc - 17) / 16])) begin
          n_bad++; $display("FAIL b2b_freq cyc=%0d got=%0d exp=%0d", cyc, freq, peaks[(cyc - 17) / 16]);
        end
      end
      if (cyc % 16 == 0 && cyc < 64) drive_frame(peaks[cyc / 16], PEAK, NOISE);
      else drive_idle();
    end
  endtask

  // A at 0, B at 2 (into shadow), C at 4 (overwrites B).
  task automatic test_overrun();
    @(negedge clk);
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      n_cmp += 3;
      if (overrun !== (cyc == 5)) begin n_bad++; $display("FAIL ovr_overrun cyc=%0d got=%b", cyc, overrun); end
      if (done !== (cyc == 17 || cyc == 33)) begin n_bad++; $display("FAIL ovr_done cyc=%0d got=%b", cyc, done); end
      if (busy !== (cyc >= 1 && cyc <= 32)) begin n_bad++; $display("FAIL ovr_busy cyc=%0d got=%b", cyc, busy); end
      if (cyc == 17) begin
        n_cmp++;
        if (freq !== 4'd2) begin n_bad++; $display("FAIL ovr_freq_a got=%0d exp=2", freq); end
      end
      if (cyc == 33) begin
        n_cmp++;
        if (freq !== 4'd6) begin n_bad++; $display("FAIL ovr_freq_c got=%0d exp=6", freq); end
      end
      case (cyc)
        0:       drive_frame(2, PEAK, NOISE);
        2:       drive_frame(4, PEAK, NOISE);
        4:       drive_frame(6, PEAK, NOISE);
        default: drive_idle();
      endcase
    end
  endtask

  // Frame at 0, pending frame at 3, reset at 8, fresh frame at 12.
  task automatic test_reset_mid();
    @(negedge clk);
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      n_cmp += 2;
      if (done !== (cyc == 29)) begin n_bad++; $display("FAIL rmid_done cyc=%0d got=%b", cyc, done); end
      if (busy !== ((cyc >= 1 && cyc <= 8) || (cyc >= 13 && cyc <= 28))) begin
        n_bad++; $display("FAIL rmid_busy cyc=%0d got=%b", cyc, busy);
      end
      if (cyc >= 9 && cyc <= 28) begin
        n_cmp++;
        if (freq !== 4'd0) begin n_bad++; $display("FAIL rmid_freq_cleared cyc=%0d got=%0d exp=0", cyc, freq); end
      end
      if (cyc == 29) begin
        n_cmp++;
        if (freq !== 4'd9) begin n_bad++; $display("FAIL rmid_freq got=%0d exp=9", freq); end
      end
      rst = (cyc == 8);
      case (cyc)
        0:       drive_frame(5, PEAK, NOISE);
        3:       drive_frame(11, PEAK, NOISE);
        12:      drive_frame(9, PEAK, NOISE);
        default: drive_idle();
      endcase
    end
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_tie();
    test_zero();
    test_extreme();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
